// File: rtl/dbg_uart_loader.sv
// UART-framed debug memory loader: decodes W/R/H/G byte frames into debug-port
// word accesses and CPU halt control, and returns ACK/NAK or read data bytes.
module dbg_uart_loader #(
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT     = 1000000,
  parameter bit BOOT_HALTED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        dbg_mem_op,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do,
  output logic [3:0]  dbg_wren,
  input  logic [31:0] dbg_di,
  output logic        cpu_n_reset
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, MEM_WR, MEM_RD, RESP} state_t;

  state_t        state, state_nx;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          is_wr;
  logic          halt;
  logic [31:0]   adr_sh, do_sh, rd_sh;
  logic [2:0]    rd_cnt;
  logic [1:0]    tx_left;

  assign to_hit      = !rx_valid && (to_cnt == TW'(TIMEOUT - 1));
  assign dbg_mem_op  = (state == MEM_WR) || (state == MEM_RD);
  assign dbg_wren    = (state == MEM_WR) ? 4'hF : 4'h0;
  assign cpu_n_reset = ~halt;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (rx_valid) state_nx = (rx_data == 8'h57 || rx_data == 8'h52) ? ADDR : RESP;
      ADDR:   if (rx_valid && byte_cnt == 2'd3) state_nx = is_wr ? DATA : MEM_RD;
              else if (to_hit) state_nx = IDLE;
      DATA:   if (rx_valid && byte_cnt == 2'd3) state_nx = MEM_WR;
              else if (to_hit) state_nx = IDLE;
      MEM_WR: state_nx = RESP;
      MEM_RD: if (rd_cnt == 3'(RD_LAT)) state_nx = RESP;
      RESP:   if (tx_valid && tx_ready && tx_left == 2'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      to_cnt   <= '0;
      is_wr    <= 1'b0;
      halt     <= BOOT_HALTED;
      adr_sh   <= '0;
      do_sh    <= '0;
      rd_sh    <= '0;
      rd_cnt   <= '0;
      tx_left  <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      dbg_adr  <= '0;
      dbg_do   <= '0;
    end else begin
      // Inter-byte watchdog only runs while a frame is partially received.
      if ((state == ADDR || state == DATA) && !rx_valid && !to_hit) to_cnt <= to_cnt + 1'b1;
      else to_cnt <= '0;

      case (state)
        IDLE: begin
          byte_cnt <= '0;
          if (rx_valid) begin
            is_wr   <= (rx_data == 8'h57);
            tx_left <= '0;
            case (rx_data)
              8'h57, 8'h52: ;
              8'h48: begin halt <= 1'b1; tx_valid <= 1'b1; tx_data <= ACK; end
              8'h47: begin halt <= 1'b0; tx_valid <= 1'b1; tx_data <= ACK; end
              default: begin tx_valid <= 1'b1; tx_data <= NAK; end
            endcase
          end
        end
        ADDR: if (rx_valid) begin
          byte_cnt <= byte_cnt + 1'b1;
          adr_sh   <= {rx_data, adr_sh[31:8]};
          if (byte_cnt == 2'd3 && !is_wr) dbg_adr <= {rx_data, adr_sh[31:10], 2'b00};
        end
        DATA: if (rx_valid) begin
          byte_cnt <= byte_cnt + 1'b1;
          do_sh    <= {rx_data, do_sh[31:8]};
          // Bus address/data only move when an access is committed.
          if (byte_cnt == 2'd3) begin
            dbg_do  <= {rx_data, do_sh[31:8]};
            dbg_adr <= {adr_sh[31:2], 2'b00};
          end
        end
        MEM_WR: begin
          tx_valid <= 1'b1;
          tx_data  <= ACK;
          tx_left  <= '0;
        end
        MEM_RD: if (rd_cnt == 3'(RD_LAT)) begin
          rd_cnt   <= '0;
          tx_valid <= 1'b1;
          tx_data  <= dbg_di[7:0];
          rd_sh    <= {8'h00, dbg_di[31:8]};
          tx_left  <= 2'd3;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
        RESP: if (tx_valid && tx_ready) begin
          if (tx_left == 2'd0) tx_valid <= 1'b0;
          else begin
            tx_data <= rd_sh[7:0];
            rd_sh   <= rd_sh >> 8;
            tx_left <= tx_left - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_uart_loader.sv
// Directed plus randomized frame traffic against a word-level memory model.
module tb_dbg_uart_loader;
  localparam int RD_LAT  = 1;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        dbg_mem_op;
  logic [31:0] dbg_adr, dbg_do, dbg_di;
  logic [3:0]  dbg_wren;
  logic        cpu_n_reset;

  int tests = 0;
  int fails = 0;
  int op_cycles = 0;
  int tx_acc = 0;
  int op_age = 0;

  logic [31:0] ram [0:255];
  bit          ram_init = 1'b0;
  logic [31:0] ref_mem [int];

  dbg_uart_loader #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT), .BOOT_HALTED(1'b1)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dbg_mem_op(dbg_mem_op), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
    .dbg_wren(dbg_wren), .dbg_di(dbg_di), .cpu_n_reset(cpu_n_reset)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_seed(input int i);
    return (i == 3) ? 32'h0885_0513 : 32'h1000_0000 + i;
  endfunction

  // Environment memory: data only valid after RD_LAT cycles of bus ownership.
  always @(posedge clk) op_age <= dbg_mem_op ? op_age + 1 : 0;
  assign dbg_di = (dbg_mem_op && op_age >= RD_LAT) ? ram[dbg_adr[9:2]] : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_seed(i);
      ram_init <= 1'b1;
    end else if (dbg_mem_op && dbg_wren == 4'hF) ram[dbg_adr[9:2]] <= dbg_do;
    if (dbg_mem_op) op_cycles++;
    if (tx_valid && tx_ready) tx_acc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic get_reply(input int n, input int hold, output logic [31:0] w);
    logic [7:0] b0;
    bit stable;
    w = '0;
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (!tx_valid && t < 200) begin tick(); t++; end
      chk("tx_present", {31'b0, tx_valid}, 32'd1);
      b0 = tx_data; stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        tick();
        if (tx_data !== b0 || tx_valid !== 1'b1) stable = 1'b0;
      end
      chk("tx_stable", {31'b0, stable}, 32'd1);
      w[8*k +: 8] = b0;
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
    chk("tx_idle_after", {31'b0, tx_valid}, 32'd0);
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [31:0] data, input int hold);
    logic [31:0] w;
    send_byte(8'h57);
    send_word(adr);
    send_word(data);
    chk("wr_op",   {31'b0, dbg_mem_op}, 32'd1);
    chk("wr_wren", {28'b0, dbg_wren}, 32'hF);
    chk("wr_adr",  dbg_adr, {adr[31:2], 2'b00});
    chk("wr_do",   dbg_do, data);
    tick();
    chk("wr_op_end", {31'b0, dbg_mem_op}, 32'd0);
    chk("wr_ack_valid", {31'b0, tx_valid}, 32'd1);
    get_reply(1, hold, w);
    chk("wr_ack", w, 32'h06);
    ref_mem[int'(adr[9:2])] = data;
  endtask

  task automatic do_read(input logic [31:0] adr, input int hold);
    logic [31:0] w, exp;
    int idx;
    idx = int'(adr[9:2]);
    exp = ref_mem.exists(idx) ? ref_mem[idx] : ram_seed(idx);
    send_byte(8'h52);
    send_word(adr);
    chk("rd_op",   {31'b0, dbg_mem_op}, 32'd1);
    chk("rd_wren", {28'b0, dbg_wren}, 32'h0);
    chk("rd_adr",  dbg_adr, {adr[31:2], 2'b00});
    for (int c = 0; c < RD_LAT; c++) tick();
    chk("rd_op_last", {31'b0, dbg_mem_op}, 32'd1);
    tick();
    chk("rd_op_end", {31'b0, dbg_mem_op}, 32'd0);
    chk("rd_tx_rise", {31'b0, tx_valid}, 32'd1);
    get_reply(4, hold, w);
    chk("rd_data", w, exp);
  endtask

  initial begin
    logic [31:0] w;
    int ops0, acc0;

    #12;
    chk("rst_nreset", {31'b0, cpu_n_reset}, 32'd0);
    chk("rst_op",     {31'b0, dbg_mem_op}, 32'd0);
    chk("rst_txv",    {31'b0, tx_valid}, 32'd0);
    chk("rst_adr",    dbg_adr, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    tick();

    do_write(32'h0002_0000, 32'h0001_0137, 0);
    do_write(32'h0002_0003, 32'hA5C3_5A3C, 1);
    chk("masked_adr", dbg_adr, 32'h0002_0000);
    do_read(32'h0002_000C, 5);

    // Abandoned frame followed by halt.
    ops0 = op_cycles;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    repeat (TIMEOUT + 10) tick();
    send_byte(8'h48);
    chk("h_nreset", {31'b0, cpu_n_reset}, 32'd0);
    chk("h_ack_now", {31'b0, tx_valid}, 32'd1);
    get_reply(1, 0, w);
    chk("h_ack", w, 32'h06);
    chk("to_no_access", op_cycles, ops0);
    send_byte(8'h47);
    chk("g_nreset", {31'b0, cpu_n_reset}, 32'd1);
    get_reply(1, 2, w);
    chk("g_ack", w, 32'h06);

    send_byte(8'hAA);
    get_reply(1, 0, w);
    chk("nak", w, 32'h15);

    for (int it = 0; it < 16; it++) begin
      logic [31:0] a, d;
      a = 32'h0002_0000 | ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
      d = $urandom;
      if ($urandom_range(0, 1) == 1) do_write(a, d, $urandom_range(0, 3));
      a = 32'h0002_0000 | ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
      do_read(a, $urandom_range(0, 3));
    end
    do_write(32'h0002_0100, 32'h1234_5678, 0);
    do_read(32'h0002_0100, 0);

    // Reset in the middle of a read access.
    send_byte(8'h52);
    send_word(32'h0002_0010);
    chk("mr_op_before", {31'b0, dbg_mem_op}, 32'd1);
    reset = 1'b1; #1;
    chk("mr_op", {31'b0, dbg_mem_op}, 32'd0);
    chk("mr_txv", {31'b0, tx_valid}, 32'd0);
    chk("mr_nreset", {31'b0, cpu_n_reset}, 32'd0);
    chk("mr_adr", dbg_adr, 32'd0);
    tick();
    reset = 1'b0;
    acc0 = tx_acc;
    tx_ready = 1'b1;
    repeat (10) tick();
    tx_ready = 1'b0;
    chk("mr_no_reply", tx_acc, acc0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
